vga_sync_receiver: RTL and testbench

//  Receive end of the 640x480@60 VGA timing link. Takes active-low hsync/vsync
//  (e.g. looped back from the timing generator or from an external source) and

---
 rtl/vga_sync_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: rebuilds the raster position from active-low hsync/vsync,
// measures the line period and the lines per frame, and reports lock status.
//
// state  | meaning
// -------+-------------------------------------------------------------
// SEARCH | waiting for LOCK_LINES consecutive lines of valid period
// HLOCK  | line timing is good; checking that a whole frame has V_TOTAL lines
// LOCKED | line and frame timing valid; visible/locked are asserted
module vga_sync_receiver #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_TOTAL     = 800,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_TOTAL     = 525,
  parameter int SYNC_STAGES = 2,
  parameter int H_TOL       = 2,
  parameter int LOCK_LINES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  px_x,
  output logic [8:0]  px_y,
  output logic        visible,
  output logic        locked,
  output logic [10:0] h_period,
  output logic [9:0]  v_lines,
  output logic [7:0]  err_count
);

  // hcnt load value accounts for the synchroniser and edge-detect delay so that
  // a same-clock loopback sees hcnt equal to the generator's own h counter.
  localparam logic [9:0]  H_LOAD    = 10'((H_VISIBLE + H_FRONT + SYNC_STAGES + 1) % H_TOTAL);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0]  V_LOAD    = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0]  V_TOT     = 10'(V_TOTAL);
  localparam logic [10:0] P_TIMEOUT = 11'(2 * H_TOTAL);
  localparam logic [10:0] P_LO      = 11'(H_TOTAL - H_TOL);
  localparam logic [10:0] P_HI      = 11'(H_TOTAL + H_TOL);
  localparam logic [10:0] P_MAX     = 11'h7FF;
  localparam logic [9:0]  L_MAX     = 10'h3FF;
  localparam logic [7:0]  LOCK_N    = 8'(LOCK_LINES);

  typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} state_t;

  logic [SYNC_STAGES-1:0] hs_sync, vs_sync;
  logic                   hs_d, vs_d;
  logic                   hs_fall, vs_fall;
  logic [9:0]             hcnt, hcnt_nxt, vcnt, vcnt_nxt;
  logic                   h_wrap;
  logic [10:0]            pcnt;
  logic [9:0]             lcnt;
  logic                   line_good, line_bad, timeout, frame_ok;
  state_t                 state, state_nxt;
  logic [7:0]             good_cnt, good_nxt;
  logic                   armed, armed_nxt;
  logic                   first_line, first_nxt;
  logic                   err_inc;

  assign hs_fall   = !hs_sync[SYNC_STAGES-1] && hs_d;
  assign vs_fall   = !vs_sync[SYNC_STAGES-1] && vs_d;
  assign timeout   = (pcnt == P_TIMEOUT);
  assign frame_ok  = (lcnt == V_TOT);
  assign line_good = hs_fall && !first_line && (pcnt >= P_LO) && (pcnt <= P_HI);
  assign line_bad  = hs_fall && !line_good;
  assign px_x      = hcnt[9:1];
  assign px_y      = vcnt[8:1];

  // Synchronise the sync inputs and keep a delayed copy for falling-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_sync <= '1;
      vs_sync <= '1;
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
    end else begin
      hs_sync[0] <= hsync_in;
      vs_sync[0] <= vsync_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        hs_sync[i] <= hs_sync[i-1];
        vs_sync[i] <= vs_sync[i-1];
      end
      hs_d <= hs_sync[SYNC_STAGES-1];
      vs_d <= vs_sync[SYNC_STAGES-1];
    end
  end

  // Next raster position: sync-edge loads take priority over free-running wrap.
  always_comb begin
    h_wrap   = 1'b0;
    hcnt_nxt = hcnt + 10'd1;
    vcnt_nxt = vcnt;
    if (hs_fall) begin
      hcnt_nxt = H_LOAD;
    end else if (hcnt == H_LAST) begin
      hcnt_nxt = '0;
      h_wrap   = 1'b1;
    end
    if (vs_fall) begin
      vcnt_nxt = V_LOAD;
    end else if (h_wrap) begin
      vcnt_nxt = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end
  end

  // Raster counters plus line-period and lines-per-frame measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt     <= '0;
      vcnt     <= '0;
      pcnt     <= '0;
      lcnt     <= '0;
      h_period <= '0;
      v_lines  <= '0;
    end else begin
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;
      if (hs_fall) begin
        h_period <= pcnt;
        pcnt     <= 11'd1;
      end else if (pcnt != P_MAX) begin
        pcnt <= pcnt + 11'd1;
      end
      if (vs_fall) begin
        v_lines <= lcnt;
        lcnt    <= hs_fall ? 10'd1 : 10'd0;
      end else if (hs_fall && lcnt != L_MAX) begin
        lcnt <= lcnt + 10'd1;
      end
    end
  end

  // Lock FSM next-state logic; any exit to SEARCH restarts the good-line run.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    armed_nxt = armed;
    first_nxt = first_line;
    err_inc   = 1'b0;
    case (state)
      SEARCH: begin
        if (hs_fall) first_nxt = 1'b0;
        if (good_cnt == LOCK_N) begin
          state_nxt = HLOCK;
          armed_nxt = 1'b0;
        end else if (line_good) begin
          good_nxt = good_cnt + 8'd1;
        end else if (line_bad) begin
          good_nxt = '0;
        end
      end
      HLOCK: begin
        if (line_bad || timeout) begin
          state_nxt = SEARCH;
          good_nxt  = '0;
          first_nxt = 1'b1;
        end else if (vs_fall) begin
          if (armed && frame_ok) state_nxt = LOCKED;
          armed_nxt = 1'b1;
        end
      end
      LOCKED: begin
        if (line_bad || timeout || (vs_fall && !frame_ok)) begin
          state_nxt = SEARCH;
          good_nxt  = '0;
          first_nxt = 1'b1;
          err_inc   = 1'b1;
        end
      end
      default: begin
        state_nxt = SEARCH;
        good_nxt  = '0;
        first_nxt = 1'b1;
      end
    endcase
  end

  // FSM state register with registered locked/visible aligned to hcnt/vcnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      good_cnt   <= '0;
      armed      <= 1'b0;
      first_line <= 1'b1;
      err_count  <= '0;
      locked     <= 1'b0;
      visible    <= 1'b0;
    end else begin
      state      <= state_nxt;
      good_cnt   <= good_nxt;
      armed      <= armed_nxt;
      first_line <= first_nxt;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
      locked  <= (state_nxt == LOCKED);
      visible <= (state_nxt == LOCKED) && (hcnt_nxt < H_VIS) && (vcnt_nxt < V_VIS);
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver. A scaled-down raster (10 clocks/line, 5 lines/frame)
// keeps frame-level scenarios short; the local generator is the reference raster.
module tb_vga_sync_receiver;

  localparam int HV = 4, HF = 1, HT = 10, HSW = 2;
  localparam int VV = 2, VF = 1, VT = 5,  VSW = 1;
  localparam int SYNC = 2, HTOL = 2, LOCKN = 4;
  localparam int HS_START = HV + HF;
  localparam int VS_START = VV + VF;

  localparam int S_PX_X = 0, S_PX_Y = 1, S_VIS = 2, S_LOCKED = 3;
  localparam int S_HPER = 4, S_VLINES = 5, S_ERR = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync_in, vsync_in;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic        visible, locked;
  logic [10:0] h_period;
  logic [9:0]  v_lines;
  logic [7:0]  err_count;

  vga_sync_receiver #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_TOTAL(VT),
    .SYNC_STAGES(SYNC), .H_TOL(HTOL), .LOCK_LINES(LOCKN)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .px_x(px_x), .px_y(px_y), .visible(visible), .locked(locked),
    .h_period(h_period), .v_lines(v_lines), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // reference timing generator with hooks for distorted lines/frames
  int   gen_h = 0, gen_v = 0, cur_len = HT, cur_vlen = VT;
  int   stretch_req = 0, vadj = 0;
  logic hs_hold = 1'b0, vs_force = 1'b0;

  always @(posedge clk) begin
    if (gen_h == cur_len - 1) begin
      gen_h   <= 0;
      cur_len <= HT + stretch_req;
      if (gen_v == cur_vlen - 1) begin
        gen_v    <= 0;
        cur_vlen <= VT + vadj;
      end else begin
        gen_v <= gen_v + 1;
      end
    end else begin
      gen_h <= gen_h + 1;
    end
  end

  assign hsync_in = hs_hold | ~((gen_h >= HS_START) && (gen_h < HS_START + HSW));
  assign vsync_in = ~vs_force & ~((gen_v >= VS_START) && (gen_v < VS_START + VSW));

  // scoreboard
  int    q_sel[$];
  int    q_exp[$];
  string q_name[$];
  int    n_cmp = 0, n_bad = 0;

  task automatic expect_eq(input int sel, input int exp, input string name);
    q_sel.push_back(sel);
    q_exp.push_back(exp);
    q_name.push_back(name);
  endtask

  function automatic int sample(input int sel);
    case (sel)
      S_PX_X:   return int'(px_x);
      S_PX_Y:   return int'(px_y);
      S_VIS:    return int'(visible);
      S_LOCKED: return int'(locked);
      S_HPER:   return int'(h_period);
      S_VLINES: return int'(v_lines);
      default:  return int'(err_count);
    endcase
  endfunction

  int    m_sel, m_exp, m_act;
  string m_name;
  always @(negedge clk) begin
    while (q_sel.size() > 0) begin
      m_sel  = q_sel.pop_front();
      m_exp  = q_exp.pop_front();
      m_name = q_name.pop_front();
      m_act  = sample(m_sel);
      n_cmp++;
      if (m_act != m_exp) begin
        n_bad++;
        $display("FAIL %s: got %0d expected %0d", m_name, m_act, m_exp);
      end
    end
  end

  task automatic wait_pos(input int v, input int h);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (gen_v == v && gen_h == h) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_pos: position v=%0d h=%0d not reached, required within 2000 clocks", v, h);
  endtask

  task automatic wait_locked(input string name);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (locked) break;
    end
    expect_eq(S_LOCKED, 1, name);
  endtask

  task automatic track(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      expect_eq(S_PX_X, gen_h / 2, "track_px_x");
      expect_eq(S_PX_Y, gen_v / 2, "track_px_y");
      expect_eq(S_VIS, (gen_h < HV && gen_v < VV) ? 1 : 0, "track_visible");
    end
  endtask

  task automatic expect_reset_outputs(input string tag);
    expect_eq(S_PX_X, 0, {tag, "_px_x"});
    expect_eq(S_PX_Y, 0, {tag, "_px_y"});
    expect_eq(S_VIS, 0, {tag, "_visible"});
    expect_eq(S_LOCKED, 0, {tag, "_locked"});
    expect_eq(S_HPER, 0, {tag, "_h_period"});
    expect_eq(S_VLINES, 0, {tag, "_v_lines"});
    expect_eq(S_ERR, 0, {tag, "_err_count"});
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, then release on a frame boundary
    repeat (3) @(posedge clk);
    #1;
    expect_reset_outputs("reset");
    n_cmp++;
    if (err_count != 8'd0) begin
      n_bad++;
      $display("FAIL reset_err_direct: got %0d expected 0", err_count);
    end
    wait_pos(0, 0);
    rst = 1'b0;

    // 1: lock sequence; frame 0 is still in SEARCH, frame 1 arms, frame 2 locks
    wait_pos(VS_START, 3);
    wait_pos(VS_START, 3);
    expect_eq(S_LOCKED, 0, "t1_armed_frame");
    wait_pos(VS_START, 2);
    expect_eq(S_LOCKED, 0, "t1_before_lock_edge");
    wait_pos(VS_START, 3);
    expect_eq(S_LOCKED, 1, "t1_lock_edge");
    n_cmp++;
    if (locked != 1'b1) begin
      n_bad++;
      $display("FAIL t1_lock_direct: got %0d expected 1", locked);
    end
    expect_eq(S_HPER, HT, "t1_h_period");
    expect_eq(S_VLINES, VT, "t1_v_lines");
    expect_eq(S_ERR, 0, "t1_err_count");
    track(VT * HT);

    // 2: line of HT+2 tolerated, line of HT+3 loses lock
    wait_pos(0, 1);
    stretch_req = HTOL;
    wait_pos(1, 0);
    stretch_req = 0;
    wait_pos(2, 8);
    expect_eq(S_HPER, HT + HTOL, "t2_h_period_tol");
    expect_eq(S_LOCKED, 1, "t2_locked_tol");
    wait_pos(2, 9);
    stretch_req = HTOL + 1;
    wait_pos(3, 0);
    stretch_req = 0;
    wait_pos(4, 7);
    expect_eq(S_LOCKED, 1, "t2_locked_before_fall");
    @(posedge clk); #1;
    expect_eq(S_LOCKED, 0, "t2_unlock");
    expect_eq(S_HPER, HT + HTOL + 1, "t2_h_period_bad");
    n_cmp++;
    if (h_period != 11'(HT + HTOL + 1)) begin
      n_bad++;
      $display("FAIL t2_h_period_direct: got %0d expected %0d", h_period, HT + HTOL + 1);
    end
    expect_eq(S_ERR, 1, "t2_err_count");
    wait_locked("t2_relock");

    // 3: one short frame, then relock two frames after the unlock
    wait_pos(4, 1);
    vadj = -1;
    wait_pos(0, 0);
    vadj = 0;
    wait_pos(VS_START, 3);
    expect_eq(S_LOCKED, 1, "t3_locked_before_short");
    expect_eq(S_VLINES, VT, "t3_v_lines_normal");
    wait_pos(VS_START, 3);
    expect_eq(S_LOCKED, 0, "t3_unlock");
    expect_eq(S_VLINES, VT - 1, "t3_v_lines_short");
    expect_eq(S_ERR, 2, "t3_err_count");
    wait_pos(VS_START, 3);
    expect_eq(S_LOCKED, 0, "t3_armed_frame");
    wait_pos(VS_START, 3);
    expect_eq(S_LOCKED, 1, "t3_relock");

    // 4: hsync held high; timeout exactly when pcnt reaches 2*HT
    wait_pos(0, HS_START + SYNC + 1);
    hs_hold = 1'b1;
    repeat (2 * HT - 1) @(posedge clk);
    #1;
    expect_eq(S_LOCKED, 1, "t4_locked_before_timeout");
    @(posedge clk); #1;
    expect_eq(S_LOCKED, 0, "t4_timeout_unlock");
    n_cmp++;
    if (locked != 1'b0) begin
      n_bad++;
      $display("FAIL t4_unlock_direct: got %0d expected 0", locked);
    end
    expect_eq(S_ERR, 3, "t4_err_count");
    wait_pos(VS_START, 0);
    hs_hold = 1'b0;
    wait_locked("t4_relock");

    // 5: one-clock reset mid-frame
    wait_pos(1, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    expect_reset_outputs("t5_reset");
    rst = 1'b0;
    wait_locked("t5_relock");
    track(VT * HT);

    // 6: 300 lock-loss events via an extra vsync pulse; counter saturates
    for (int k = 1; k <= 300; k++) begin
      wait_locked("t6_locked");
      wait_pos(0, HS_START);
      vs_force = 1'b1;
      repeat (SYNC + 1) @(posedge clk);
      #1;
      vs_force = 1'b0;
      expect_eq(S_LOCKED, 0, "t6_unlock");
      expect_eq(S_ERR, (k > 255) ? 255 : k, "t6_err_count");
    end
    n_cmp++;
    if (err_count != 8'd255) begin
      n_bad++;
      $display("FAIL t6_saturate_direct: got %0d expected 255", err_count);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
